parking_gate_actuator: RTL and testbench

//   Downstream of car_parking_system: turns its level gate_open request into barrier

---
 rtl/parking_gate_actuator_if.sv | 24 ++
 rtl/parking_gate_actuator.sv | 147 ++++++++++++++
 tb/tb_parking_gate_actuator.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/parking_gate_actuator_if.sv
// Barrier actuator signal bundle: requests and limit switches in, motor drive and status out.
// The master side drives the inputs; the actuator connects through the slave modport.
interface parking_gate_actuator_if;
  logic gate_open;
  logic limit_up;
  logic limit_down;
  logic obstruct;
  logic fault_clear;
  logic motor_up;
  logic motor_down;
  logic gate_is_open;
  logic fault;
  logic car_passed;

  modport master (
    output gate_open, limit_up, limit_down, obstruct, fault_clear,
    input  motor_up, motor_down, gate_is_open, fault, car_passed
  );

  modport slave (
    input  gate_open, limit_up, limit_down, obstruct, fault_clear,
    output motor_up, motor_down, gate_is_open, fault, car_passed
  );
endinterface

// File: rtl/parking_gate_actuator.sv
// Barrier motor controller: drives up/down from the limit switches, holds open while a
// car is present, reverses on obstruction and latches a fault on timeout/conflict/retries.
module parking_gate_actuator #(
  parameter int HOLD_CYCLES    = 500,
  parameter int TRAVEL_TIMEOUT = 2000,
  parameter int REVERSE_LIMIT  = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  parking_gate_actuator_if.slave  gate_if
);

  localparam int TMAX_VAL = (HOLD_CYCLES > TRAVEL_TIMEOUT) ? HOLD_CYCLES : TRAVEL_TIMEOUT;
  localparam int TW       = $clog2(TMAX_VAL + 1);
  localparam int RW       = $clog2(REVERSE_LIMIT + 1);

  localparam logic [TW-1:0] TIMER_MAX   = {TW{1'b1}};
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_TIMEOUT - 1);
  localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYCLES - 1);
  localparam logic [RW:0]   REV_LIMIT   = (RW + 1)'(REVERSE_LIMIT);

  typedef enum logic [2:0] {
    ST_CLOSED  = 3'd0,
    ST_OPENING = 3'd1,
    ST_OPEN    = 3'd2,
    ST_CLOSING = 3'd3,
    ST_FAULT   = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [RW-1:0]   rev_cnt_q, rev_cnt_d;
  logic            obs_prev_q;
  logic            motor_up_q, motor_up_d;
  logic            motor_down_q, motor_down_d;
  logic            gate_is_open_q, gate_is_open_d;
  logic            fault_q, fault_d;
  logic            car_passed_q, car_passed_d;

  logic            demand_s;
  logic            limit_conflict_s;
  logic [RW:0]     rev_inc_s;
  logic [TW-1:0]   timer_inc_s;

  assign demand_s         = gate_if.gate_open | gate_if.obstruct;
  assign limit_conflict_s = gate_if.limit_up & gate_if.limit_down;
  assign rev_inc_s        = {1'b0, rev_cnt_q} + {{RW{1'b0}}, 1'b1};
  assign timer_inc_s      = (timer_q == TIMER_MAX) ? timer_q : (timer_q + {{(TW-1){1'b0}}, 1'b1});

  // Next-state and reversal bookkeeping; a conflicting limit pair overrides everything but FAULT.
  always_comb begin
    state_d   = state_q;
    rev_cnt_d = rev_cnt_q;
    if ((state_q != ST_FAULT) && limit_conflict_s) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_CLOSED: begin
          if (gate_if.gate_open) state_d = ST_OPENING;
          else                   state_d = ST_CLOSED;
        end
        ST_OPENING: begin
          if (gate_if.limit_up)            state_d = ST_OPENING == ST_OPENING ? ST_OPEN : ST_OPEN;
          else if (timer_q == TRAVEL_LAST) state_d = ST_FAULT;
          else                             state_d = ST_OPENING;
        end
        ST_OPEN: begin
          if (!demand_s && (timer_q == HOLD_LAST)) state_d = ST_CLOSING;
          else                                     state_d = ST_OPEN;
        end
        ST_CLOSING: begin
          if (gate_if.limit_down) begin
            state_d   = ST_CLOSED;
            rev_cnt_d = {RW{1'b0}};
          end else if (demand_s) begin
            rev_cnt_d = rev_inc_s[RW-1:0];
            if (rev_inc_s < REV_LIMIT) state_d = ST_OPENING;
            else                       state_d = ST_FAULT;
          end else if (timer_q == TRAVEL_LAST) begin
            state_d = ST_FAULT;
          end else begin
            state_d = ST_CLOSING;
          end
        end
        ST_FAULT: begin
          if (gate_if.fault_clear) begin
            state_d   = ST_CLOSING;
            rev_cnt_d = {RW{1'b0}};
          end else begin
            state_d = ST_FAULT;
          end
        end
        default: state_d = ST_FAULT;
      endcase
    end
  end

  // Timer restarts on any state change and while a car or request keeps the gate open.
  always_comb begin
    if (state_d != state_q) begin
      timer_d = {TW{1'b0}};
    end else if ((state_q == ST_OPEN) && demand_s) begin
      timer_d = {TW{1'b0}};
    end else if ((state_q == ST_OPENING) || (state_q == ST_OPEN) || (state_q == ST_CLOSING)) begin
      timer_d = timer_inc_s;
    end else begin
      timer_d = timer_q;
    end
    motor_up_d     = (state_d == ST_OPENING);
    motor_down_d   = (state_d == ST_CLOSING);
    gate_is_open_d = (state_d == ST_OPEN);
    fault_d        = (state_d == ST_FAULT);
    car_passed_d   = (state_q == ST_OPEN) && obs_prev_q && !gate_if.obstruct;
  end

  // State, counters and registered outputs; reset re-homes the barrier via CLOSING.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_CLOSING;
      timer_q        <= {TW{1'b0}};
      rev_cnt_q      <= {RW{1'b0}};
      obs_prev_q     <= 1'b0;
      motor_up_q     <= 1'b0;
      motor_down_q   <= 1'b0;
      gate_is_open_q <= 1'b0;
      fault_q        <= 1'b0;
      car_passed_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      rev_cnt_q      <= rev_cnt_d;
      obs_prev_q     <= gate_if.obstruct;
      motor_up_q     <= motor_up_d;
      motor_down_q   <= motor_down_d;
      gate_is_open_q <= gate_is_open_d;
      fault_q        <= fault_d;
      car_passed_q   <= car_passed_d;
    end
  end

  assign gate_if.motor_up     = motor_up_q;
  assign gate_if.motor_down   = motor_down_q;
  assign gate_if.gate_is_open = gate_is_open_q;
  assign gate_if.fault        = fault_q;
  assign gate_if.car_passed   = car_passed_q;

endmodule

// File: tb/tb_parking_gate_actuator.sv
// Scoreboard bench for parking_gate_actuator: a behavioural model pushes expected outputs
// per clock, which are popped and compared one edge later, plus directed scenario checks.
module tb_parking_gate_actuator;

  localparam int HOLD = 10;
  localparam int TT   = 20;
  localparam int RL   = 3;
  localparam int TMAX = 31;

  localparam int M_CLOSED  = 0;
  localparam int M_OPENING = 1;
  localparam int M_OPEN    = 2;
  localparam int M_CLOSING = 3;
  localparam int M_FAULT   = 4;

  typedef struct packed {
    logic mu;
    logic md;
    logic gio;
    logic flt;
    logic cp;
  } exp_t;

  logic clk;
  logic reset;
  parking_gate_actuator_if gif ();

  parking_gate_actuator #(
    .HOLD_CYCLES   (HOLD),
    .TRAVEL_TIMEOUT(TT),
    .REVERSE_LIMIT (RL)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .gate_if(gif)
  );

  exp_t exp_q[$];
  int   checks_r;
  int   errors_r;
  int   m_state;
  int   m_timer;
  int   m_rev;
  bit   m_obs;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (checks=%0d errors=%0d)", checks_r, errors_r);
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_r++;
    if (obs !== exp) begin
      errors_r++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_CLOSING;
    m_timer = 0;
    m_rev   = 0;
    m_obs   = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step();
    int   ns;
    bit   hold;
    exp_t e;
    hold = gif.gate_open || gif.obstruct;
    ns   = m_state;
    if (m_state == M_FAULT) begin
      if (gif.fault_clear) begin
        ns    = M_CLOSING;
        m_rev = 0;
      end
    end else if (gif.limit_up && gif.limit_down) begin
      ns = M_FAULT;
    end else if (m_state == M_CLOSED) begin
      if (gif.gate_open) ns = M_OPENING;
    end else if (m_state == M_OPENING) begin
      if (gif.limit_up) ns = M_OPEN;
      else if (m_timer == TT - 1) ns = M_FAULT;
    end else if (m_state == M_OPEN) begin
      if (!hold && m_timer == HOLD - 1) ns = M_CLOSING;
    end else begin
      if (gif.limit_down) begin
        ns    = M_CLOSED;
        m_rev = 0;
      end else if (hold) begin
        m_rev = m_rev + 1;
        ns    = (m_rev < RL) ? M_OPENING : M_FAULT;
      end else if (m_timer == TT - 1) begin
        ns = M_FAULT;
      end
    end
    e.cp = (m_state == M_OPEN) && m_obs && !gif.obstruct;
    if (ns != m_state || (m_state == M_OPEN && hold)) m_timer = 0;
    else if (m_state == M_OPENING || m_state == M_OPEN || m_state == M_CLOSING)
      m_timer = (m_timer < TMAX) ? m_timer + 1 : m_timer;
    m_obs   = gif.obstruct;
    m_state = ns;
    e.mu  = (ns == M_OPENING);
    e.md  = (ns == M_CLOSING);
    e.gio = (ns == M_OPEN);
    e.flt = (ns == M_FAULT);
    exp_q.push_back(e);
  endtask

  // One clock: predict from current inputs, then compare the DUT just after the edge.
  task automatic tick();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_val("sb_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_val("motor_up",     gif.motor_up,     e.mu);
      check_val("motor_down",   gif.motor_down,   e.md);
      check_val("gate_is_open", gif.gate_is_open, e.gio);
      check_val("fault",        gif.fault,        e.flt);
      check_val("car_passed",   gif.car_passed,   e.cp);
      if (gif.motor_up && gif.motor_down) check_val("motor_excl", 32'd1, 32'd0);
    end
  endtask

  task automatic run_until_md(input string tag, output int cycles, output int open_cnt, output int cp_cnt);
    cycles = 0; open_cnt = 0; cp_cnt = 0;
    do begin
      tick();
      cycles++;
      if (gif.gate_is_open) open_cnt++;
      if (gif.car_passed) cp_cnt++;
    end while (!gif.motor_down && cycles < 40);
    if (!gif.motor_down) check_val(tag, 32'd0, 32'd1);
  endtask

  task automatic open_gate();
    gif.gate_open = 1'b1; tick();
    gif.gate_open = 1'b0; gif.limit_down = 1'b0;
    tick(); tick();
    gif.limit_up = 1'b1; tick();
  endtask

  task automatic close_gate();
    gif.limit_up = 1'b0;
    tick(); tick();
    gif.limit_down = 1'b1; tick();
  endtask

  initial begin
    int c, oc, cc, md_cnt;
    checks_r = 0; errors_r = 0;
    reset = 1'b0;
    gif.gate_open = 1'b0; gif.limit_up = 1'b0; gif.limit_down = 1'b0;
    gif.obstruct = 1'b0;  gif.fault_clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_mu",  gif.motor_up, 32'd0);
    check_val("rst_md",  gif.motor_down, 32'd0);
    check_val("rst_gio", gif.gate_is_open, 32'd0);
    check_val("rst_flt", gif.fault, 32'd0);
    check_val("rst_cp",  gif.car_passed, 32'd0);

    // Homing after reset release
    reset = 1'b1;
    md_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (gif.motor_down) md_cnt++;
    end
    gif.limit_down = 1'b1; tick();
    check_val("s1_md_cycles", md_cnt, 32'd5);
    check_val("s1_closed_md", gif.motor_down, 32'd0);

    // Normal open, hold and close
    open_gate();
    run_until_md("s2_hold_bound", c, oc, cc);
    check_val("s2_open_cycles", oc + 1, 32'd10);
    close_gate();

    // Car under the barrier restarts the hold
    open_gate();
    gif.obstruct = 1'b1;
    repeat (15) tick();
    check_val("s3_held_open", gif.gate_is_open, 32'd1);
    gif.obstruct = 1'b0;
    run_until_md("s3_hold_bound", c, oc, cc);
    check_val("s3_close_delay", c, 32'd10);
    check_val("s3_car_passed", cc, 32'd1);
    close_gate();

    // Repeated reversals end in FAULT
    for (int p = 0; p < 3; p++) begin
      if (p == 0) open_gate();
      run_until_md("s4_hold_bound", c, oc, cc);
      gif.limit_up = 1'b0; tick();
      gif.obstruct = 1'b1; tick();
      gif.obstruct = 1'b0;
      if (p < 2) begin
        check_val("s4_rev_up", gif.motor_up, 32'd1);
        tick();
        gif.limit_up = 1'b1; tick();
      end else begin
        check_val("s4_fault", gif.fault, 32'd1);
        check_val("s4_fault_mu", gif.motor_up, 32'd0);
        check_val("s4_fault_md", gif.motor_down, 32'd0);
      end
    end
    gif.gate_open = 1'b1; gif.obstruct = 1'b1; tick(); tick();
    check_val("s4_fault_sticky", gif.fault, 32'd1);
    gif.gate_open = 1'b0; gif.obstruct = 1'b0;
    gif.fault_clear = 1'b1; tick();
    check_val("s4_clear_md", gif.motor_down, 32'd1);
    gif.fault_clear = 1'b0;
    close_gate();

    // Opening travel timeout
    gif.gate_open = 1'b1; tick();
    gif.gate_open = 1'b0; gif.limit_down = 1'b0;
    repeat (19) tick();
    check_val("s5_pre_fault", gif.fault, 32'd0);
    tick();
    check_val("s5_fault", gif.fault, 32'd1);
    check_val("s5_fault_mu", gif.motor_up, 32'd0);
    gif.fault_clear = 1'b1; tick();
    gif.fault_clear = 1'b0;
    close_gate();

    // Conflicting limits, then async reset mid-opening
    gif.limit_up = 1'b1; tick();
    check_val("s6_conflict", gif.fault, 32'd1);
    gif.limit_up = 1'b0; gif.fault_clear = 1'b1; tick();
    gif.fault_clear = 1'b0; tick();
    gif.gate_open = 1'b1; tick();
    gif.gate_open = 1'b0; gif.limit_down = 1'b0;
    tick(); tick();
    check_val("s6_opening", gif.motor_up, 32'd1);
    #3;
    reset = 1'b0;
    #1;
    check_val("s6_async_mu", gif.motor_up, 32'd0);
    check_val("s6_async_md", gif.motor_down, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) tick();
    gif.limit_down = 1'b1; tick();

    // Constrained-random traffic against the model
    for (int i = 0; i < 300; i++) begin
      gif.gate_open   = ($urandom_range(7) == 0);
      gif.obstruct    = ($urandom_range(5) == 0);
      gif.fault_clear = ($urandom_range(3) == 0);
      gif.limit_up    = (m_state == M_OPEN) || (m_state == M_OPENING && $urandom_range(3) == 0);
      gif.limit_down  = (m_state == M_CLOSED) || (m_state == M_CLOSING && $urandom_range(3) == 0);
      if ($urandom_range(63) == 0) begin
        gif.limit_up = 1'b1; gif.limit_down = 1'b1;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks_r, errors_r);
    $finish;
  end

endmodule
